// File: rtl/scs8hd_deglitch_2.sv
// Synchronizing level deglitcher: Q follows D only after FILTER_CYCLES consecutive agreeing samples.
// Optional abort counter on GLITCH_CNT when SCS8HD_DEGLITCH_GLITCH_CNT_EN is defined.
module scs8hd_deglitch_2 #(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       D,
  output logic       Q,
  output logic       Q_N,
  output logic       RISE,
  output logic       FALL,
  output logic       BUSY
`ifdef SCS8HD_DEGLITCH_GLITCH_CNT_EN
  ,
  output logic [7:0] GLITCH_CNT
`endif
);

  if ((FILTER_CYCLES == 0) || (FILTER_CYCLES > 15) || (SYNC_STAGES < 2) || (SYNC_STAGES > 3))
  begin : g_bad_params
    $error("scs8hd_deglitch_2: FILTER_CYCLES must be 1..15 and SYNC_STAGES 2 or 3");
  end

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_QUAL_H = 2'd1,
    S_HIGH   = 2'd2,
    S_QUAL_L = 2'd3
  } state_t;

  localparam logic [3:0] LAST    = 4'(FILTER_CYCLES - 1);
  localparam bit         DIRECT  = (FILTER_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   ds;
  state_t                 state, state_nx;
  logic [3:0]             cnt, cnt_nx;
  logic                   q_nx;
  logic                   abort;

  always_ff @(posedge CLK) begin
    if (RESET) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], D};
  end

  assign ds = sync[SYNC_STAGES-1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    abort    = 1'b0;
    unique case (state)
      S_LOW: begin
        if (ds) begin
          if (DIRECT) begin
            state_nx = S_HIGH;
            cnt_nx   = '0;
          end else begin
            state_nx = S_QUAL_H;
            cnt_nx   = 4'd1;
          end
        end
      end
      S_QUAL_H: begin
        if (!ds) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
          abort    = 1'b1;
        end else if (cnt == LAST) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_HIGH: begin
        if (!ds) begin
          if (DIRECT) begin
            state_nx = S_LOW;
            cnt_nx   = '0;
          end else begin
            state_nx = S_QUAL_L;
            cnt_nx   = 4'd1;
          end
        end
      end
      S_QUAL_L: begin
        if (ds) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
          abort    = 1'b1;
        end else if (cnt == LAST) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = S_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  // Q is held in its own flop (not decoded) so edge pulses compare old vs. new level.
  assign q_nx = (state_nx == S_HIGH) || (state_nx == S_QUAL_L);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_LOW;
      cnt   <= '0;
      Q     <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      Q     <= q_nx;
      RISE  <= q_nx & ~Q;
      FALL  <= ~q_nx & Q;
    end
  end

  assign Q_N  = ~Q;
  assign BUSY = (state == S_QUAL_H) || (state == S_QUAL_L);

`ifdef SCS8HD_DEGLITCH_GLITCH_CNT_EN
  always_ff @(posedge CLK) begin
    if (RESET)                            GLITCH_CNT <= '0;
    else if (abort && (GLITCH_CNT != '1)) GLITCH_CNT <= GLITCH_CNT + 8'd1;
  end
`endif

endmodule
